// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - pipeline hazard/memory handshake bundle between datapath and stall controller
//
// Signals:
//   IDEX_MemRead_i, IDEX_RDaddr_i    load in EX and its destination register
//   IFID_RS1addr_i, IFID_RS2addr_i   source registers of the instruction in ID
//   Branch_i                         taken branch resolved in ID
//   EXMEM_MemAcc_i, mem_ack_i        memory access in MEM and its completion
//   mem_req_o                        data memory request
//   PCWrite_o .. MEMWB_Bubble_o      pipeline register enables / flushes / bubbles
// Modports:
//   master  datapath side (drives hazard inputs, consumes controls)
//   slave   stall controller side
interface pipeline_stall_ctrl_if;
    logic       IDEX_MemRead_i;
    logic [4:0] IDEX_RDaddr_i;
    logic [4:0] IFID_RS1addr_i;
    logic [4:0] IFID_RS2addr_i;
    logic       Branch_i;
    logic       EXMEM_MemAcc_i;
    logic       mem_ack_i;
    logic       mem_req_o;
    logic       PCWrite_o;
    logic       IFID_Write_o;
    logic       IFID_Flush_o;
    logic       IDEX_Write_o;
    logic       IDEX_Bubble_o;
    logic       EXMEM_Write_o;
    logic       MEMWB_Bubble_o;

    modport master (
        output IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               Branch_i, EXMEM_MemAcc_i, mem_ack_i,
        input  mem_req_o, PCWrite_o, IFID_Write_o, IFID_Flush_o,
               IDEX_Write_o, IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o
    );

    modport slave (
        input  IDEX_MemRead_i, IDEX_RDaddr_i, IFID_RS1addr_i, IFID_RS2addr_i,
               Branch_i, EXMEM_MemAcc_i, mem_ack_i,
        output mem_req_o, PCWrite_o, IFID_Write_o, IFID_Flush_o,
               IDEX_Write_o, IDEX_Bubble_o, EXMEM_Write_o, MEMWB_Bubble_o
    );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - hazard/stall scheduler for the 5-stage pipeline
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low
//   bus          pipeline_stall_ctrl_if.slave (hazard inputs, pipe controls, mem req/ack)
//   err_o        sticky memory-timeout flag
//   stall_cnt_o  saturating count of cycles with PCWrite_o=0
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    pipeline_stall_ctrl_if.slave  bus,
    output logic                  err_o,
    output logic [CNT_W-1:0]      stall_cnt_o
);

    localparam int WCW = $clog2(MEM_TIMEOUT) + 1;

    localparam logic [1:0] ST_RUN  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [1:0]     state;
    logic [WCW-1:0] wait_cnt;

    logic lu;
    logic mstall;
    logic mem_req;
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
    logic exmem_write;
    logic memwb_bubble;

    assign lu = bus.IDEX_MemRead_i && (bus.IDEX_RDaddr_i != 5'd0) &&
                ((bus.IDEX_RDaddr_i == bus.IFID_RS1addr_i) ||
                 (bus.IDEX_RDaddr_i == bus.IFID_RS2addr_i));

    // A dropped EXMEM_MemAcc_i while waiting removes the request, so mstall
    // falls and the cycle is handled exactly like an ack.
    assign mem_req = rst_i && (state != ST_ERR) && bus.EXMEM_MemAcc_i;
    assign mstall  = mem_req && !bus.mem_ack_i;

    always_comb begin
        pc_write     = 1'b0;
        ifid_write   = 1'b0;
        ifid_flush   = 1'b0;
        idex_write   = 1'b0;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b0;
        memwb_bubble = 1'b0;
        if (rst_i) begin
            if (state == ST_ERR || mstall) begin
                // full freeze; only the MEM/WB write-back is squashed
                memwb_bubble = 1'b1;
            end else begin
                pc_write    = 1'b1;
                ifid_write  = 1'b1;
                idex_write  = 1'b1;
                exmem_write = 1'b1;
                if (lu) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (bus.Branch_i) begin
                    ifid_flush = 1'b1;
                end
            end
        end
    end

    assign bus.mem_req_o      = mem_req;
    assign bus.PCWrite_o      = pc_write;
    assign bus.IFID_Write_o   = ifid_write;
    assign bus.IFID_Flush_o   = ifid_flush;
    assign bus.IDEX_Write_o   = idex_write;
    assign bus.IDEX_Bubble_o  = idex_bubble;
    assign bus.EXMEM_Write_o  = exmem_write;
    assign bus.MEMWB_Bubble_o = memwb_bubble;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            err_o    <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mstall) begin
                        state    <= ST_WAIT;
                        wait_cnt <= WCW'(1);
                    end
                end
                ST_WAIT: begin
                    if (mstall) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                        if (wait_cnt == WCW'(MEM_TIMEOUT - 1)) begin
                            state <= ST_ERR;
                            err_o <= 1'b1;
                        end
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (!pc_write && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    localparam int MEM_TIMEOUT = 16;
    localparam int CNT_W       = 5;

    // {mem_req, PCWrite, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Write, MEMWB_Bubble}
    localparam logic [7:0] O_RST    = 8'b0000_0000;
    localparam logic [7:0] O_RUN    = 8'b0110_1010;
    localparam logic [7:0] O_RUNREQ = 8'b1110_1010;
    localparam logic [7:0] O_LU     = 8'b0000_1110;
    localparam logic [7:0] O_BR     = 8'b0111_1010;
    localparam logic [7:0] O_FRZ    = 8'b1000_0001;
    localparam logic [7:0] O_ERR    = 8'b0000_0001;

    logic             clk;
    logic             rst_n;
    logic             err;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       outs;
    int               n_chk;
    int               n_fail;

    pipeline_stall_ctrl_if bus ();

    pipeline_stall_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .bus         (bus.slave),
        .err_o       (err),
        .stall_cnt_o (stall_cnt)
    );

    assign outs = {bus.mem_req_o, bus.PCWrite_o, bus.IFID_Write_o, bus.IFID_Flush_o,
                   bus.IDEX_Write_o, bus.IDEX_Bubble_o, bus.EXMEM_Write_o, bus.MEMWB_Bubble_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic [4:0] rdaddr, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic br, input logic acc, input logic ack);
        bus.IDEX_MemRead_i = rd;
        bus.IDEX_RDaddr_i  = rdaddr;
        bus.IFID_RS1addr_i = rs1;
        bus.IFID_RS2addr_i = rs2;
        bus.Branch_i       = br;
        bus.EXMEM_MemAcc_i = acc;
        bus.mem_ack_i      = ack;
        #2;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        check_val("reset_outs", 32'(outs), 32'(O_RST));
        check_val("reset_err", 32'(err), 32'd0);
        check_val("reset_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("idle_run", 32'(outs), 32'(O_RUN));
        step();

        // load-use on rs1
        drive(1'b1, 5'd5, 5'd5, 5'd3, 1'b0, 1'b0, 1'b0);
        check_val("lu_rs1", 32'(outs), 32'(O_LU));
        step();
        drive(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
        check_val("lu_clear", 32'(outs), 32'(O_RUN));
        check_val("lu_cnt", 32'(stall_cnt), 32'd1);
        // load-use on rs2
        drive(1'b1, 5'd9, 5'd1, 5'd9, 1'b0, 1'b0, 1'b0);
        check_val("lu_rs2", 32'(outs), 32'(O_LU));
        step();

        // x0 never hazards
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("x0_exempt", 32'(outs), 32'(O_RUN));
        step();
        check_val("x0_cnt", 32'(stall_cnt), 32'd2);

        // branch with simultaneous load-use: stall wins, branch next cycle
        drive(1'b1, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
        check_val("br_lu", 32'(outs), 32'(O_LU));
        step();
        drive(1'b0, 5'd7, 5'd7, 5'd0, 1'b1, 1'b0, 1'b0);
        check_val("br_only", 32'(outs), 32'(O_BR));
        step();
        check_val("br_cnt", 32'(stall_cnt), 32'd3);

        // memory ack after 3 wait cycles; load-use suppressed by freeze
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0);
            check_val($sformatf("mwait%0d", i), 32'(outs), 32'(O_FRZ));
            step();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_val("mack", 32'(outs), 32'(O_RUNREQ));
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("mack_run", 32'(outs), 32'(O_RUN));
        check_val("mack_cnt", 32'(stall_cnt), 32'd6);

        // access withdrawn without ack while waiting behaves as ack
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        check_val("drop_as_ack", 32'(outs), 32'(O_BR));
        step();
        check_val("drop_cnt", 32'(stall_cnt), 32'd7);

        // no ack: MEM_TIMEOUT freeze cycles then ERR
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            check_val($sformatf("to_frz%0d", i), 32'(outs), 32'(O_FRZ));
            check_val($sformatf("to_err%0d", i), 32'(err), 32'd0);
            step();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
        check_val("err_set", 32'(err), 32'd1);
        check_val("err_outs", 32'(outs), 32'(O_ERR));
        check_val("err_cnt", 32'(stall_cnt), 32'd23);
        for (int i = 0; i < 12; i++) step();
        check_val("err_sticky", 32'(err), 32'd1);
        check_val("err_outs2", 32'(outs), 32'(O_ERR));
        check_val("cnt_sat", 32'(stall_cnt), 32'd31);

        // async reset out of ERR
        rst_n = 1'b0;
        #1;
        check_val("rst_err_outs", 32'(outs), 32'(O_RST));
        check_val("rst_err_flag", 32'(err), 32'd0);
        check_val("rst_err_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("post_err_run", 32'(outs), 32'(O_RUN));
        step();

        // async reset in the middle of a wait
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        check_val("pre_rst_cnt", 32'(stall_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        check_val("rst_wait_outs", 32'(outs), 32'(O_RST));
        check_val("rst_wait_cnt", 32'(stall_cnt), 32'd0);
        step();
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        check_val("post_wait_run", 32'(outs), 32'(O_RUN));
        check_val("post_wait_err", 32'(err), 32'd0);

        // wait counter must have been cleared: full timeout needed again
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
            check_val($sformatf("to2_err%0d", i), 32'(err), 32'd0);
            step();
        end
        check_val("to2_err_set", 32'(err), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
